hex_display_ctrl: RTL and testbench

Parametrised multi-digit hex display controller for the DE-board seven-segment banks. It captures an N-digit hex value on a load strobe and produces per-digit segment patterns with leading-zero suppression and per-digit blinking. It also produces a time-multiplexed single-bus output for scanned displays. It sits between the datapath/status logic and the board HEX pins, replacing per-nibble decoder instances.

---
 rtl/hex_disp_pkg.sv | 23 ++
 rtl/hex_display_ctrl_if.sv | 23 ++
 rtl/hex_disp_scan.sv | 61 ++++++
 rtl/hex_display_ctrl.sv | 82 ++++++++
 tb/tb_hex_display_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hex_disp_pkg.sv
// Shared seven-segment constants and helpers for the hex display controller.
// Glyphs are stored in active-low form, {g,f,e,d,c,b,a}; apply_pol adapts them to the board polarity.
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index n holds the glyph for hex digit n (entries listed from F down to 0).
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return GLYPH[nib];
  endfunction

  function automatic logic [6:0] apply_pol(input logic [6:0] seg_al, input logic active_low);
    return active_low ? seg_al : ~seg_al;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value/control inputs and segment outputs of the hex display controller.
// master drives the value and controls; slave is the controller itself.
interface hex_display_ctrl_if #(
  parameter int N_DIGITS = 6
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic                    blank_lz;
  logic [N_DIGITS-1:0]     blink_en;
  logic [7*N_DIGITS-1:0]   seg;
  logic [6:0]              mux_seg;
  logic [N_DIGITS-1:0]     mux_an;

  modport master (
    output load, value, blank_lz, blink_en,
    input  seg, mux_seg, mux_an
  );

  modport slave (
    input  load, value, blank_lz, blink_en,
    output seg, mux_seg, mux_an
  );
endinterface

// File: rtl/hex_disp_scan.sv
// Scan divider and digit index driving the time-multiplexed segment/anode bus.
// Registered; anode and segments update on the same edge from the same next index; no backpressure.
module hex_disp_scan
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7*N_DIGITS-1:0] pat,
  output logic [6:0]            mux_seg,
  output logic [N_DIGITS-1:0]   mux_an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = apply_pol(SEG_BLANK, ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          mux_seg_q, mux_seg_d;
  logic [N_DIGITS-1:0] mux_an_q, mux_an_d;
  logic [N_DIGITS-1:0] an_onehot;
  logic                scan_wrap;

  // Both mux registers take idx_d so the anode and its segments always move together.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    an_onehot = N_DIGITS'(1) << idx_d;
    mux_an_d  = (ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    mux_seg_d = pat[7*int'(idx_d) +: 7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      mux_seg_q  <= SEG_OFF;
      mux_an_q   <= AN_OFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      mux_seg_q  <= mux_seg_d;
      mux_an_q   <= mux_an_d;
    end
  end

  assign mux_seg = mux_seg_q;
  assign mux_an  = mux_an_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display: value capture, leading-zero suppression, per-digit blink, static and scanned outputs.
// Load to pins takes 2 edges, live controls 1 edge; outputs are free-running registers with no backpressure.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  hex_display_ctrl_if.slave  bus
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = apply_pol(SEG_BLANK, ACTIVE_LOW != 0);

  logic [4*N_DIGITS-1:0] val_q, val_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [7*N_DIGITS-1:0] seg_q, seg_d;
  logic                  blink_wrap;
  logic                  zero_above;
  logic                  blank;
  logic [3:0]            nib;
  logic [6:0]            mux_seg;
  logic [N_DIGITS-1:0]   mux_an;

  always_comb begin
    val_d       = bus.load ? bus.value : val_q;
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_wrap;
  end

  // Walk from the most significant digit down so zero_above means "this and every higher nibble is 0".
  always_comb begin
    zero_above = 1'b1;
    blank      = 1'b0;
    nib        = 4'h0;
    seg_d      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nib        = val_q[4*i +: 4];
      zero_above = zero_above & (nib == 4'h0);
      blank      = (bus.blank_lz && zero_above && (i != 0)) || (phase_q && bus.blink_en[i]);
      seg_d[7*i +: 7] = apply_pol(blank ? SEG_BLANK : hex_to_seg(nib), ACTIVE_LOW != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= {N_DIGITS{SEG_OFF}};
    end else begin
      val_q       <= val_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
    end
  end

  hex_disp_scan #(
    .N_DIGITS   (N_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .pat     (seg_d),
    .mux_seg (mux_seg),
    .mux_an  (mux_an)
  );

  assign bus.seg     = seg_q;
  assign bus.mux_seg = mux_seg;
  assign bus.mux_an  = mux_an;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed plus random checks of hex_display_ctrl against an arithmetic model of the display rules.
module tb_hex_display_ctrl;

  localparam int ND = 4;
  localparam int BD = 8;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hex_display_ctrl_if #(.N_DIGITS(ND)) bus ();

  hex_display_ctrl #(
    .N_DIGITS   (ND),
    .BLINK_DIV  (BD),
    .SCAN_DIV   (SD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [15:0] val_m     = '0;
  int          k_m       = 0;   // non-reset edges since the last reset edge
  bit          model_ok  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Digit i is blanked by LZ when the value shifted down by i nibbles is zero (never digit 0).
  function automatic logic [27:0] exp_pat(input logic [15:0] v, input bit ph,
                                          input logic blz, input logic [3:0] ben);
    logic [27:0] r;
    logic [15:0] upper;
    bit          blank;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      upper = v >> (4 * i);
      blank = (blz && (i > 0) && (upper == 16'h0)) || (ph && ben[i]);
      r[7*i +: 7] = blank ? 7'b1111111 : glyph[upper[3:0]];
    end
    return r;
  endfunction

  task automatic step();
    logic [27:0] se;
    logic [6:0]  ms;
    logic [3:0]  ma;
    int          idx;
    if (rst) begin
      se = '1;
      ms = '1;
      ma = '1;
    end else begin
      se  = exp_pat(val_m, ((k_m / BD) % 2) == 1, bus.blank_lz, bus.blink_en);
      idx = ((k_m + 1) / SD) % ND;
      ma  = ~(4'b0001 << idx);
      ms  = se[7*idx +: 7];
    end
    @(posedge clk);
    if (rst) begin
      val_m    = '0;
      k_m      = 0;
      model_ok = 1'b1;
    end else begin
      if (bus.load) val_m = bus.value;
      k_m++;
    end
    #1;
    if (model_ok) begin
      check("seg", 32'(bus.seg), 32'(se));
      check("mux_seg", 32'(bus.mux_seg), 32'(ms));
      check("mux_an", 32'(bus.mux_an), 32'(ma));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] rnd;

  initial begin
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_lz = 1'b0;
    bus.blink_en = '0;

    // reset and idle
    rst = 1'b1;
    steps(3);
    check("rst_seg", 32'(bus.seg), 32'h0FFF_FFFF);
    check("rst_an", 32'(bus.mux_an), 32'hF);
    rst = 1'b0;
    step();
    check("release_zeros", 32'(bus.seg), 32'({4{7'b1000000}}));

    // load latency
    bus.value = 16'h3A5F;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    step();
    check("load_3A5F", 32'(bus.seg), 32'({7'b0110000, 7'b0001000, 7'b0010010, 7'b0001110}));

    // leading-zero suppression
    bus.blank_lz = 1'b1;
    bus.value    = 16'h0070;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
    step();
    check("lz_0070", 32'(bus.seg), 32'({7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}));
    bus.value    = 16'h0000;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
    step();
    check("lz_0000", 32'(bus.seg), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));

    // blink on digit 1, scan stepping checked every cycle by the model
    bus.blank_lz = 1'b0;
    bus.value    = 16'h1234;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
    bus.blink_en = 4'b0010;
    steps(40);

    // reset while idx=2 and phase=1
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(12);
    rst = 1'b1;
    step();
    check("midrst_seg", 32'(bus.seg), 32'h0FFF_FFFF);
    check("midrst_an", 32'(bus.mux_an), 32'hF);
    rst = 1'b0;
    step();
    check("postrst_seg", 32'(bus.seg), 32'({4{7'b1000000}}));
    check("postrst_an", 32'(bus.mux_an), 32'hE);

    // SCAN_DIV boundary / generic random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      bus.load  = ($urandom_range(0, 3) == 0);
      rnd       = $urandom;
      bus.value = 16'(rnd[15:0] >> (4 * $urandom_range(0, 4)));
      bus.blank_lz = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) bus.blink_en = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
